gpio_ctrl: RTL and testbench
============================

// Module: gpio_ctrl
// PURPOSE
//  Parametrised memory-mapped GPIO controller on the SoC local bus, GPIO_W pins.
//  Per-pin output data and direction, atomic set/clear, synchronised input sampling, rising/falling edge detection.
//  Sticky, write-1-to-clear interrupt status drives one level irq to the CPU.
//  Drop-in replacement for the single-register LED GPIO: same bus protocol; DATA_OUT stays at 0x00.
// PARAMETERS
//  ADDR_W       32  local bus address width
//  DATA_W       32  local bus data width (fixed at 32)
//  STRB_W       DATA_W/8  byte strobes
//  GPIO_W       32  pin count, 1..32; register bits [31:GPIO_W] read 0, writes ignored
//  SYNC_STAGES  2   input synchroniser depth, >=2
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous, active-high reset
//  gpio_in   in   GPIO_W  pad inputs, asynchronous to clk
//  gpio_out  out  GPIO_W  output data (= DATA_OUT)
//  gpio_oe   out  GPIO_W  output enable per pin, 1 = drive (= DIR)
//  irq       out  1       |(IRQ_STATUS), level
//  waddr/wdata/wen/wstrb  in  ADDR_W/DATA_W/1/STRB_W  write request
//  wready    out  1       tied 1
//  raddr/ren in   ADDR_W/1  read request
//  rdata     out  DATA_W  read data
//  rvalid    out  1       read data valid
// BEHAVIOUR
//  Reset: all registers, sync chain, prev-sample, rdata, rvalid, irq = 0; gpio_out = gpio_oe = 0 (all pins inputs).
//  Map, byte strobes honoured on rw:
//    0x00 DATA_OUT rw | 0x04 DATA_IN ro | 0x08 DIR rw | 0x0C OUT_SET wo (rd 0)
//    0x10 OUT_CLR wo (rd 0) | 0x14 RISE_EN rw | 0x18 FALL_EN rw | 0x1C IRQ_STATUS rw1c
//  Writes: wen single cycle, effective at the next clk edge; unmapped addresses are ignored.
//  OUT_SET/OUT_CLR: DATA_OUT |= / &= ~ (wdata masked by strobes), same latency as a DATA_OUT write.
//  Read: rdata and rvalid both registered; ren in cycle N -> rvalid=1 and rdata in N+1.
//    Without ren, rvalid=0 and rdata=0. Unmapped/write-only addresses read 0 with rvalid=1.
//    Back-to-back ren is allowed: one rvalid per ren.
//  Input path: gpio_in -> SYNC_STAGES flops -> s. DATA_IN = s, readable after SYNC_STAGES edges.
//    All pins are sampled regardless of DIR.
//  Edge detect: prev <= s each cycle. rise = s&~prev&RISE_EN; fall = ~s&prev&FALL_EN.
//    A status bit sets at edge SYNC_STAGES+1 after the pin change.
//  IRQ_STATUS: bit set by rise|fall, cleared by writing 1. A set in the same cycle as a clear wins (edge never lost).
//    Status is sticky while enables are later cleared; clearing an enable does not clear status.
//  irq = |IRQ_STATUS, driven from flops (glitch-free), asserted the same cycle the status bit is visible.
//  Pulses shorter than 1 clk may be missed (no requirement). Reset mid-operation drops pending reads: no rvalid.
// TESTING (GPIO_W=8, SYNC_STAGES=2)
//  1 Reset, read all 8 addresses -> rvalid 1 cycle after each ren, rdata 0; gpio_oe=0, irq=0.
//  2 Write DIR=0xFF, DATA_OUT=0x0F; SET 0xA0; CLR 0x03 -> gpio_out=0xAC, gpio_oe=0xFF; write 0x12345678 wstrb=0001 to DATA_OUT -> 0x78.
//  3 gpio_in 0x00->0x5A -> DATA_IN reads 0x5A when ren is issued >=2 cycles later; an earlier read returns 0x00.
//  4 RISE_EN=0x01, FALL_EN=0x02; pin0 rise, pin1 fall, pin2 rise -> IRQ_STATUS=0x03 at edge 3; irq=1; write 0x01 -> 0x02; write 0x02 -> irq=0.
//  5 W1C of bit0 in the same cycle a new pin0 rise is detected -> bit0 stays 1, irq stays 1.
//  6 Assert rst while ren is pending and IRQ_STATUS=0xFF -> next cycle rvalid=0, status=0, irq=0, gpio_oe=0.

Source files
------------

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: output data/direction, atomic set/clear,
// synchronised inputs, edge-triggered sticky interrupt status and level irq.
module gpio_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8,
    parameter int GPIO_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wen,
    input  logic [STRB_W-1:0] wstrb,
    output logic              wready,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    localparam logic [ADDR_W-1:0] A_DATA_OUT = ADDR_W'('h00);
    localparam logic [ADDR_W-1:0] A_DATA_IN  = ADDR_W'('h04);
    localparam logic [ADDR_W-1:0] A_DIR      = ADDR_W'('h08);
    localparam logic [ADDR_W-1:0] A_OUT_SET  = ADDR_W'('h0C);
    localparam logic [ADDR_W-1:0] A_OUT_CLR  = ADDR_W'('h10);
    localparam logic [ADDR_W-1:0] A_RISE_EN  = ADDR_W'('h14);
    localparam logic [ADDR_W-1:0] A_FALL_EN  = ADDR_W'('h18);
    localparam logic [ADDR_W-1:0] A_IRQ_STAT = ADDR_W'('h1C);

    logic [GPIO_W-1:0] data_out, dir, rise_en, fall_en, irq_status;
    logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_W-1:0] s, prev;
    logic [GPIO_W-1:0] rise, fall, status_clr, status_next;
    logic [DATA_W-1:0] wmask, wdata_m, rd_val;
    logic [GPIO_W-1:0] wbits, bmask, rd_sel;

    assign wready   = 1'b1;
    assign gpio_out = data_out;
    assign gpio_oe  = dir;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            wmask[8*i +: 8] = {8{wstrb[i]}};
        end
    end

    assign wdata_m = wdata & wmask;
    assign wbits   = wdata_m[GPIO_W-1:0];
    assign bmask   = wmask[GPIO_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev & rise_en;
    assign fall = ~s & prev & fall_en;

    // New edges are OR-ed in after the clear so a coincident W1C never loses one
    assign status_clr  = (wen && waddr == A_IRQ_STAT) ? wbits : '0;
    assign status_next = (irq_status & ~status_clr) | rise | fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            dir        <= '0;
            rise_en    <= '0;
            fall_en    <= '0;
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= status_next;
            irq        <= |status_next;
            if (wen) begin
                case (waddr)
                    A_DATA_OUT: data_out <= (data_out & ~bmask) | wbits;
                    A_OUT_SET:  data_out <= data_out | wbits;
                    A_OUT_CLR:  data_out <= data_out & ~wbits;
                    A_DIR:      dir      <= (dir & ~bmask) | wbits;
                    A_RISE_EN:  rise_en  <= (rise_en & ~bmask) | wbits;
                    A_FALL_EN:  fall_en  <= (fall_en & ~bmask) | wbits;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        case (raddr)
            A_DATA_OUT: rd_sel = data_out;
            A_DATA_IN:  rd_sel = s;
            A_DIR:      rd_sel = dir;
            A_RISE_EN:  rd_sel = rise_en;
            A_FALL_EN:  rd_sel = fall_en;
            A_IRQ_STAT: rd_sel = irq_status;
            default:    rd_sel = '0;
        endcase
        rd_val = '0;
        rd_val[GPIO_W-1:0] = rd_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rdata  <= ren ? rd_val : '0;
            rvalid <= ren;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl (GPIO_W=8): reads push expected data from a
// register-level model; a negedge monitor pops and compares on every rvalid.
module tb_gpio_ctrl;

    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [GW-1:0] gpio_in, gpio_out, gpio_oe;
    logic          irq;
    logic [31:0]   waddr, wdata, raddr, rdata;
    logic          wen, ren, wready, rvalid;
    logic [3:0]    wstrb;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];

    logic [GW-1:0] m_out, m_dir, m_rise, m_fall, m_stat, m_in, pins;

    always #5 clk = ~clk;

    gpio_ctrl #(.ADDR_W(32), .DATA_W(32), .STRB_W(4), .GPIO_W(GW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
        .irq(irq), .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb),
        .wready(wready), .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rvalid: got rvalid=%b rdata=%h, expected no read data", rvalid, rdata);
            end else begin
                chk("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [GW-1:0] v;
        case (a)
            32'h00:  v = m_out;
            32'h04:  v = m_in;
            32'h08:  v = m_dir;
            32'h14:  v = m_rise;
            32'h18:  v = m_fall;
            32'h1C:  v = m_stat;
            default: v = '0;
        endcase
        return {24'h0, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] mk, dm;
        logic [GW-1:0] lo, bm;
        wen = 1'b1; waddr = a; wdata = d; wstrb = st;
        tick();
        wen = 1'b0;
        for (int i = 0; i < 4; i++) mk[8*i +: 8] = st[i] ? 8'hFF : 8'h00;
        dm = d & mk;
        lo = dm[GW-1:0];
        bm = mk[GW-1:0];
        case (a)
            32'h00: m_out  = (m_out & ~bm) | lo;
            32'h0C: m_out  = m_out | lo;
            32'h10: m_out  = m_out & ~lo;
            32'h08: m_dir  = (m_dir & ~bm) | lo;
            32'h14: m_rise = (m_rise & ~bm) | lo;
            32'h18: m_fall = (m_fall & ~bm) | lo;
            32'h1C: m_stat = m_stat & ~lo;
            default: ;
        endcase
    endtask

    task automatic rd(input logic [31:0] a);
        ren = 1'b1; raddr = a;
        exp_q.push_back(model_rd(a));
        tick();
        ren = 1'b0;
    endtask

    task automatic check_pins();
        chk("gpio_out", gpio_out, m_out);
        chk("gpio_oe", gpio_oe, m_dir);
        chk("irq", irq, |m_stat);
    endtask

    // Pin change lands in status on the third edge, not before
    task automatic set_pins(input logic [GW-1:0] v);
        logic [GW-1:0] old;
        old = pins;
        pins = v;
        gpio_in = v;
        tick();
        tick();
        chk("irq_before_edge3", irq, |m_stat);
        tick();
        m_in = v;
        m_stat = m_stat | (v & ~old & m_rise) | (~v & old & m_fall);
        chk("irq_after_edge3", irq, |m_stat);
    endtask

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_stat = '0; m_in = '0;
    endtask

    initial begin
        logic [31:0] addrs [10];
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h3C};
        rst = 1'b1; wen = 1'b0; ren = 1'b0; waddr = '0; wdata = '0; wstrb = '0; raddr = '0;
        gpio_in = '0; pins = '0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        // reset state and all-address reads
        check_pins();
        for (int i = 0; i < 8; i++) rd(32'(i * 4));
        tick();

        // output data, direction, set/clear, byte strobes
        wr(32'h08, 32'hFF, 4'hF);
        wr(32'h00, 32'h0F, 4'hF);
        wr(32'h0C, 32'hA0, 4'hF);
        wr(32'h10, 32'h03, 4'hF);
        chk("out_set_clr", gpio_out, 32'hAC);
        chk("oe_all", gpio_oe, 32'hFF);
        wr(32'h00, 32'h12345678, 4'b0001);
        chk("out_strb", gpio_out, 32'h78);
        wr(32'h08, 32'h12345600, 4'b1110);
        check_pins();
        rd(32'h00); rd(32'h08); rd(32'h0C); rd(32'h10);

        // synchroniser latency on DATA_IN
        gpio_in = 8'h5A;
        rd(32'h04);
        pins = 8'h5A; m_in = 8'h5A;
        tick();
        rd(32'h04);
        tick();

        // edge detect and W1C
        wr(32'h14, 32'h01, 4'hF);
        wr(32'h18, 32'h02, 4'hF);
        set_pins(8'h5D);
        chk("status_03", m_stat, 32'h03);
        rd(32'h1C);
        wr(32'h1C, 32'h01, 4'hF);
        rd(32'h1C);
        check_pins();
        wr(32'h1C, 32'h02, 4'hF);
        chk("irq_cleared", irq, 1'b0);
        rd(32'h1C);

        // clear coinciding with a new pin0 rise
        set_pins(8'h5C);
        set_pins(8'h5D);
        set_pins(8'h5C);
        gpio_in = 8'h5D;
        tick();
        tick();
        wr(32'h1C, 32'h01, 4'hF);
        pins = 8'h5D; m_in = 8'h5D;
        m_stat = m_stat | 8'h01;
        chk("set_beats_clear", irq, 1'b1);
        rd(32'h1C);
        tick();
        check_pins();

        // randomised traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) wr(addrs[$urandom_range(0, 9)], $urandom, 4'($urandom));
            else if (r <= 7) rd(addrs[$urandom_range(0, 9)]);
            else if (r == 8) set_pins(8'($urandom));
            else check_pins();
        end
        tick();

        // reset with a read in flight and all status bits set
        wr(32'h14, 32'hFF, 4'hF);
        wr(32'h18, 32'hFF, 4'hF);
        wr(32'h1C, 32'hFF, 4'hF);
        set_pins(~pins);
        chk("status_ff", m_stat, 32'hFF);
        rd(32'h1C);
        ren = 1'b1; raddr = 32'h1C; rst = 1'b1;
        tick();
        ren = 1'b0; rst = 1'b0;
        model_reset();
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_oe", gpio_oe, 32'h0);
        chk("rst_out", gpio_out, 32'h0);
        rd(32'h1C);
        tick();
        tick();
        m_in = pins;
        rd(32'h04);
        rd(32'h14);
        tick();
        tick();

        chk("reads_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
